// File: rtl/apu_pkg.sv
// Shared types, decode tables and helpers for the APU frame sequencer.
package apu_pkg;

    localparam int STEP_W = 3;

    typedef enum logic {
        MODE_4STEP = 1'b0,
        MODE_5STEP = 1'b1
    } mode_e;

    typedef enum logic [STEP_W-1:0] {
        STEP_0 = 3'd0,
        STEP_1 = 3'd1,
        STEP_2 = 3'd2,
        STEP_3 = 3'd3,
        STEP_4 = 3'd4
    } step_e;

    // Per-step action tables, bit s = action taken on a tick while at step s.
    localparam logic [4:0] Q_TABLE_4   = 5'b01111;
    localparam logic [4:0] H_TABLE_4   = 5'b01010;
    localparam logic [4:0] IRQ_TABLE_4 = 5'b01000;
    localparam logic [4:0] Q_TABLE_5   = 5'b10111;
    localparam logic [4:0] H_TABLE_5   = 5'b10010;
    localparam logic [4:0] IRQ_TABLE_5 = 5'b00000;

    typedef struct packed {
        logic q;
        logic h;
        logic irq;
    } step_action_t;

    // What a tick at the given step does in the given mode.
    function automatic step_action_t decode_step(input mode_e mode, input step_e step);
        step_action_t act;
        if (mode == MODE_5STEP) begin
            act.q   = Q_TABLE_5[step];
            act.h   = H_TABLE_5[step];
            act.irq = IRQ_TABLE_5[step];
        end else begin
            act.q   = Q_TABLE_4[step];
            act.h   = H_TABLE_4[step];
            act.irq = IRQ_TABLE_4[step];
        end
        return act;
    endfunction

    // Step that follows the given one, wrapping at the last step of the mode.
    function automatic step_e next_step(input mode_e mode, input step_e step);
        step_e last_step;
        last_step = (mode == MODE_5STEP) ? STEP_4 : STEP_3;
        if (step == last_step) begin
            return STEP_0;
        end
        return step_e'(step + 3'd1);
    endfunction

endpackage

// File: rtl/frame_write_delay.sv
// Pending-config register and restart delay counter for the $4017-style write.
module frame_write_delay
    import apu_pkg::*;
#(
    parameter int WRITE_DELAY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic cfg_we,
    input  logic cfg_mode,
    input  logic cfg_irq_inhibit,
    output logic pending,
    output logic apply,
    output logic apply_mode,
    output logic apply_inhibit
);

    logic [2:0] count;
    mode_e      pend_mode;
    logic       pend_inhibit;

    // Latch a write and count down to the restart; a new write reloads the full delay.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            count        <= 3'd0;
            pend_mode    <= MODE_4STEP;
            pend_inhibit <= 1'b0;
        end else if (cfg_we) begin
            count        <= 3'(WRITE_DELAY);
            pend_mode    <= mode_e'(cfg_mode);
            pend_inhibit <= cfg_irq_inhibit;
        end else if (count != 3'd0) begin
            count <= count - 3'd1;
        end
    end

    // The last pending clock is the apply edge; a write on that edge restarts the wait instead.
    assign pending       = (count != 3'd0);
    assign apply         = (count == 3'd1) && !cfg_we;
    assign apply_mode    = pend_mode;
    assign apply_inhibit = pend_inhibit;

endmodule

// File: rtl/frame_sequencer.sv
// APU frame sequencer: 4/5-step step FSM, quarter/half-frame strobes and frame IRQ.
module frame_sequencer
    import apu_pkg::*;
#(
    parameter int WRITE_DELAY = 2,
    parameter bit IRQ_EN      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_240hz,
    input  logic             cfg_we,
    input  logic             cfg_mode,
    input  logic             cfg_irq_inhibit,
    input  logic             irq_ack,
    output logic             quarter_frame,
    output logic             half_frame,
    output logic             irq,
    output logic [STEP_W-1:0] step
);

    logic         pending;
    logic         apply;
    logic         apply_mode;
    logic         apply_inhibit;
    mode_e        mode;
    logic         inhibit;
    step_e        step_q;
    logic         burst;
    logic         tick_ok;
    step_action_t action;

    frame_write_delay #(
        .WRITE_DELAY (WRITE_DELAY)
    ) u_write_delay (
        .clk             (clk),
        .reset           (reset),
        .cfg_we          (cfg_we),
        .cfg_mode        (cfg_mode),
        .cfg_irq_inhibit (cfg_irq_inhibit),
        .pending         (pending),
        .apply           (apply),
        .apply_mode      (apply_mode),
        .apply_inhibit   (apply_inhibit)
    );

    // A tick counts only when no write is being accepted or waiting to apply.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        tick_ok = enable_240hz && !cfg_we && !pending;
        action  = decode_step(mode, step_q);
    end

    // Step FSM with registered strobes; an apply into 5-step fires Q+H one clock later.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode          <= MODE_4STEP;
            inhibit       <= 1'b0;
            step_q        <= STEP_0;
            burst         <= 1'b0;
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
        end else begin
            quarter_frame <= burst || (tick_ok && action.q);
            half_frame    <= burst || (tick_ok && action.h);
            burst         <= apply && (mode_e'(apply_mode) == MODE_5STEP);
            if (apply) begin
                mode    <= mode_e'(apply_mode);
                inhibit <= apply_inhibit;
                step_q  <= STEP_0;
            end else if (tick_ok) begin
                step_q <= next_step(mode, step_q);
            end
        end
    end

    assign step = step_q;

    if (IRQ_EN) begin : g_irq
        logic irq_q;

        // Frame IRQ flag: inhibit write clears at once, a set event beats an acknowledge.
        always_ff @(posedge clk) begin
            if (reset) begin
                irq_q <= 1'b0;
            end else if (cfg_we && cfg_irq_inhibit) begin
                irq_q <= 1'b0;
            end else if (tick_ok && action.irq && !inhibit) begin
                irq_q <= 1'b1;
            end else if (irq_ack) begin
                irq_q <= 1'b0;
            end
        end

        assign irq = irq_q;
    end else begin : g_no_irq
        assign irq = 1'b0;
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed testbench for frame_sequencer (WRITE_DELAY=2, IRQ_EN=1).
module tb_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_240hz = 1'b0;
    logic       cfg_we = 1'b0;
    logic       cfg_mode = 1'b0;
    logic       cfg_irq_inhibit = 1'b0;
    logic       irq_ack = 1'b0;
    logic       quarter_frame;
    logic       half_frame;
    logic       irq;
    logic [2:0] step;

    int checks = 0;
    int failures = 0;

    // Observed vector is {quarter_frame, half_frame, irq, step[2:0]}.
    logic [5:0] obs;

    frame_sequencer #(
        .WRITE_DELAY (2),
        .IRQ_EN      (1'b1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable_240hz    (enable_240hz),
        .cfg_we          (cfg_we),
        .cfg_mode        (cfg_mode),
        .cfg_irq_inhibit (cfg_irq_inhibit),
        .irq_ack         (irq_ack),
        .quarter_frame   (quarter_frame),
        .half_frame      (half_frame),
        .irq             (irq),
        .step            (step)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Drive one clock of inputs, let the edge pass, then capture outputs 1 time unit later.
    task automatic cycle(input logic we, input logic md, input logic inh,
                         input logic tk, input logic ack);
        cfg_we          = we;
        cfg_mode        = md;
        cfg_irq_inhibit = inh;
        enable_240hz    = tk;
        irq_ack         = ack;
        @(posedge clk);
        #1;
        cfg_we          = 1'b0;
        cfg_mode        = 1'b0;
        cfg_irq_inhibit = 1'b0;
        enable_240hz    = 1'b0;
        irq_ack         = 1'b0;
        obs = {quarter_frame, half_frame, irq, step};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        if (obs !== 6'b000000) begin
            failures++;
            $display("FAIL reset_state: got %b expected %b", obs, 6'b000000);
        end
        checks++;
        reset = 1'b0;
    endtask

    task automatic test_four_step();
        logic [5:0] exp_tick [8];
        exp_tick = '{6'b100001, 6'b110010, 6'b100011, 6'b111000,
                     6'b101001, 6'b111010, 6'b101011, 6'b111000};
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 0, 1, 0);
            if (obs !== exp_tick[k]) begin
                failures++;
                $display("FAIL four_step_tick%0d: got %b expected %b", k + 1, obs, exp_tick[k]);
            end
            checks++;
            cycle(0, 0, 0, 0, 0);
            if (obs !== (exp_tick[k] & 6'b001111)) begin
                failures++;
                $display("FAIL four_step_idle%0d: got %b expected %b", k + 1, obs,
                         exp_tick[k] & 6'b001111);
            end
            checks++;
        end
    endtask

    task automatic test_five_step();
        logic [5:0] exp_wr [4];
        logic [5:0] exp_tick [5];
        exp_wr   = '{6'b000000, 6'b000000, 6'b000000, 6'b110000};
        exp_tick = '{6'b100001, 6'b110010, 6'b100011, 6'b000100, 6'b110000};
        cycle(0, 0, 0, 0, 1);
        if (obs !== 6'b000000) begin
            failures++;
            $display("FAIL ack_clears_irq: got %b expected %b", obs, 6'b000000);
        end
        checks++;
        for (int k = 0; k < 4; k++) begin
            cycle(k == 0, 1, 0, 0, 0);
            if (obs !== exp_wr[k]) begin
                failures++;
                $display("FAIL five_step_apply_clk%0d: got %b expected %b", k + 1, obs, exp_wr[k]);
            end
            checks++;
        end
        cycle(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 0, 1, 0);
            if (obs !== exp_tick[k]) begin
                failures++;
                $display("FAIL five_step_tick%0d: got %b expected %b", k + 1, obs, exp_tick[k]);
            end
            checks++;
            cycle(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_inhibit();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        if (obs !== 6'b000000) begin
            failures++;
            $display("FAIL four_step_apply_no_pulse: got %b expected %b", obs, 6'b000000);
        end
        checks++;
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0);
        if (obs !== 6'b111000) begin
            failures++;
            $display("FAIL irq_set_step3: got %b expected %b", obs, 6'b111000);
        end
        checks++;
        cycle(1, 0, 1, 0, 0);
        if (obs !== 6'b000000) begin
            failures++;
            $display("FAIL inhibit_clears_irq: got %b expected %b", obs, 6'b000000);
        end
        checks++;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0);
        if (obs !== 6'b110000) begin
            failures++;
            $display("FAIL inhibit_blocks_irq: got %b expected %b", obs, 6'b110000);
        end
        checks++;
    endtask

    task automatic test_write_with_tick();
        logic [5:0] exp_seq [5];
        exp_seq = '{6'b100001, 6'b000001, 6'b000001, 6'b000000, 6'b000000};
        for (int k = 0; k < 5; k++) begin
            cycle(k == 1, 0, 0, k < 3, 0);
            if (obs !== exp_seq[k]) begin
                failures++;
                $display("FAIL write_tick_clk%0d: got %b expected %b", k, obs, exp_seq[k]);
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_seq [6];
        exp_seq = '{6'b100001, 6'b000001, 6'b000001, 6'b000001, 6'b000000, 6'b000000};
        for (int k = 0; k < 6; k++) begin
            cycle(k == 1 || k == 2, k == 1, 0, k == 0, 0);
            if (obs !== exp_seq[k]) begin
                failures++;
                $display("FAIL back_to_back_clk%0d: got %b expected %b", k, obs, exp_seq[k]);
            end
            checks++;
        end
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0);
        if (obs !== 6'b111000) begin
            failures++;
            $display("FAIL back_to_back_mode4: got %b expected %b", obs, 6'b111000);
        end
        checks++;
    endtask

    task automatic test_ack_and_reset();
        cycle(0, 0, 0, 0, 1);
        if (obs !== 6'b000000) begin
            failures++;
            $display("FAIL ack_alone_a: got %b expected %b", obs, 6'b000000);
        end
        checks++;
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0);
        if (obs !== 6'b100011) begin
            failures++;
            $display("FAIL reach_step3: got %b expected %b", obs, 6'b100011);
        end
        checks++;
        cycle(0, 0, 0, 1, 1);
        if (obs !== 6'b111000) begin
            failures++;
            $display("FAIL set_beats_ack: got %b expected %b", obs, 6'b111000);
        end
        checks++;
        cycle(0, 0, 0, 0, 1);
        if (obs !== 6'b000000) begin
            failures++;
            $display("FAIL ack_alone_b: got %b expected %b", obs, 6'b000000);
        end
        checks++;
        cycle(1, 1, 0, 0, 0);
        reset = 1'b1;
        cycle(0, 0, 0, 0, 0);
        reset = 1'b0;
        if (obs !== 6'b000000) begin
            failures++;
            $display("FAIL reset_mid_pending: got %b expected %b", obs, 6'b000000);
        end
        checks++;
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 0);
            if (obs !== 6'b000000) begin
                failures++;
                $display("FAIL reset_aborts_write_clk%0d: got %b expected %b", k, obs, 6'b000000);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_four_step();
        test_five_step();
        test_inhibit();
        test_write_with_tick();
        test_back_to_back();
        test_ack_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
